sfx_voice: RTL
==============

SFX_VOICE -- requirements
Module: sfx_voice

Interface
REQ-001 Parameter BIT_WIDTH, default 8: sample amplitude width; the sample output is BIT_WIDTH+1 bits, matching the PWM duty input.
REQ-002 Parameter SAMPLE_DIV, default 256: clk cycles per sample tick, minimum 2.
REQ-003 Parameter PERIOD_W, default 12: width of the tone half-period in sample ticks.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 trigger  input  1  single-cycle pulse that starts or restarts the effect.
REQ-007 start_period  input  PERIOD_W  initial half-period, sampled on trigger; the value 0 is treated as 1.
REQ-008 sweep_up  input  1  sweep direction, sampled on trigger: 1 = period grows (pitch falls), 0 = period shrinks.
REQ-009 sweep_step  input  8  period change applied per envelope step, sampled on trigger.
REQ-010 env_len  input  8  sample ticks per volume decrement, sampled on trigger; the value 0 is treated as 1.
REQ-011 busy  output  1  high while the state is PLAY.
REQ-012 sample  output  BIT_WIDTH+1  PWM duty value; MSB always 0.
REQ-013 sample_valid  output  1  one-cycle pulse marking that sample has just updated.

Function
REQ-014 The tick divider shall be free-running from reset, count 0..SAMPLE_DIV-1, and assert tick in the cycle where the count equals SAMPLE_DIV-1.
REQ-015 The FSM shall have two states: IDLE and PLAY.
REQ-016 On a cycle with trigger=1, in any state, the next state shall be PLAY with:
  - volume = 2^BIT_WIDTH-1
  - period_reg = max(start_period,1)
  - phase = 0, env_cnt = 0, square = 1
  - sweep_up, sweep_step and env_len latched.
REQ-017 Trigger shall take priority over a coincident tick; that tick shall be ignored.
REQ-018 On each tick in PLAY, phase shall increment; when phase+1 >= period_reg, phase shall reset to 0 and square shall toggle.
REQ-019 On each tick in PLAY, env_cnt shall increment; when it reaches env_len-1, env_cnt shall reset to 0, volume shall decrement by 1, and period_reg shall sweep.
REQ-020 The period sweep shall be a saturating add or subtract: the result is clamped to [1, 2^PERIOD_W-1] and never wraps.
REQ-021 When volume decrements to 0, the state shall return to IDLE on that same edge.
REQ-022 In PLAY, sample shall equal {1'b0, square ? volume : 0}; in IDLE, sample shall equal 0.
REQ-023 sample shall be registered and updated on the same edge that processes the tick; sample_valid shall be high for exactly the following cycle.
REQ-024 A trigger while already in PLAY shall restart the effect per REQ-016 with no IDLE cycle.
REQ-025 Inputs other than trigger shall be ignored outside the trigger cycle.

Reset
REQ-026 On rst=1, the module shall enter IDLE with:
  - divider = 0, phase = 0, env_cnt = 0, volume = 0, period_reg = 1
  - square = 0, sample = 0, sample_valid = 0, busy = 0.
REQ-027 rst shall override trigger, and a reset asserted mid-effect shall abort the effect immediately.

Configuration
REQ-028 When SFX_NOISE_EN is defined, the module shall add:
  - input port noise_sel (1 bit), sampled on trigger
  - a 15-bit LFSR (taps 15,14; seed 15'h0001 on reset and on trigger) that advances instead of toggling square when noise_sel=1; square then takes the LFSR LSB.
REQ-029 When SFX_NOISE_EN is undefined, the module shall have no noise_sel port and no LFSR, and shall produce square-wave output only.

Structure
REQ-030 The shared package audio_pkg shall hold the FSM state enum (IDLE, PLAY), the VOL_MAX function of BIT_WIDTH, and the LFSR seed and tap constants.
REQ-031 The tick divider shall be the sub-module sample_tick_gen, with parameter SAMPLE_DIV and ports clk, rst, tick.
REQ-032 sample shall connect directly to the duty input of the downstream PWM generator with the same BIT_WIDTH.

Verification
REQ-033 Bench parameters are SAMPLE_DIV=4, BIT_WIDTH=8, PERIOD_W=12.
REQ-034 Reset held for 3 cycles -> all outputs are 0 and busy=0; after release, the first tick occurs exactly 4 cycles later.
REQ-035 trigger with start_period=2, env_len=1, sweep_step=0 -> busy rises the next cycle, sample alternates 255, 255, 0, 0 across ticks (amplitude then decays by 1 per tick), and busy falls after exactly 255 ticks.
REQ-036 trigger with start_period=4090, sweep_up=1, sweep_step=16 -> period_reg saturates at 4095 and never wraps; with sweep_up=0, start_period=5, sweep_step=16 -> period_reg = 1 after the first step.
REQ-037 Retrigger at tick 100 of an effect -> volume returns to 255 on the next edge, busy stays high throughout, and sample_valid never pulses twice in one tick.
REQ-038 trigger coincident with a tick, and rst asserted mid-PLAY -> the trigger wins over the tick; the reset forces IDLE with sample=0 on the next edge.
REQ-039 With SFX_NOISE_EN defined, noise_sel=1 and start_period=1 -> the first 15 square values follow the LFSR sequence from seed 1 and repeat after 32767 ticks.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types and constants for the sound-effect voice:
//                FSM state encoding, full-scale volume helper and the
//                noise LFSR seed/tap constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Voice state; explicit 1-bit encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } voice_state_t;

    // 15-bit Fibonacci LFSR, feedback from bits 15 and 14 (1-based)
    localparam int unsigned c_LFSR_W    = 15;
    localparam logic [14:0] c_LFSR_SEED = 15'h0001;
    localparam logic [14:0] c_LFSR_TAPS = 15'h6000;

    // Full-scale amplitude for a given sample width
    function automatic int unsigned VOL_MAX(input int unsigned bw);
        return (32'd1 << bw) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Free-running sample-rate divider. Counts 0..SAMPLE_DIV-1
//                and flags tick while the count sits at SAMPLE_DIV-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 256
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 c_CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SAMPLE_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Modulo-SAMPLE_DIV counter, restarts from zero on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Tick is the terminal-count decode
    always_comb begin
        tick = (r_cnt == c_LAST);
    end

endmodule
`default_nettype wire

// File: rtl/sfx_voice.sv
`default_nettype none
// ============================================================================
//  Module      : sfx_voice
//  Description : One-shot sound-effect voice. A trigger starts a square (or,
//                optionally, noise) tone whose half-period sweeps and whose
//                volume decays one step every env_len sample ticks. The
//                registered sample feeds a PWM duty input directly.
//  Options     : SFX_NOISE_EN - adds noise_sel port and a 15-bit LFSR that
//                replaces the square toggle when selected.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfx_voice
    import audio_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int SAMPLE_DIV = 256,
    parameter int PERIOD_W   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic [PERIOD_W-1:0]  start_period,
    input  logic                 sweep_up,
    input  logic [7:0]           sweep_step,
    input  logic [7:0]           env_len,
`ifdef SFX_NOISE_EN
    input  logic                 noise_sel,
`endif
    output logic                 busy,
    output logic [BIT_WIDTH:0]   sample,
    output logic                 sample_valid
);

    localparam logic [BIT_WIDTH-1:0] c_VOL_MAX = BIT_WIDTH'(VOL_MAX(BIT_WIDTH));
    localparam logic [PERIOD_W-1:0]  c_PER_MAX = {PERIOD_W{1'b1}};
    // Wide enough for period + step without overflow
    localparam int                   c_SW_W    = ((PERIOD_W > 8) ? PERIOD_W : 8) + 1;

    voice_state_t          r_state;
    voice_state_t          w_state_next;
    logic                  w_tick;
    logic [BIT_WIDTH-1:0]  r_volume;
    logic [PERIOD_W-1:0]   r_period;
    logic [PERIOD_W-1:0]   r_phase;
    logic [7:0]            r_env_cnt;
    logic [7:0]            r_env_len;
    logic [7:0]            r_sweep_step;
    logic                  r_sweep_up;
    logic                  r_square;
    logic [BIT_WIDTH:0]    r_sample;
    logic                  r_sample_valid;

    logic                  w_play_tick;
    logic                  w_phase_wrap;
    logic                  w_env_step;
    logic                  w_last_step;
    logic [c_SW_W-1:0]     w_per_ext;
    logic [c_SW_W-1:0]     w_step_ext;
    logic [c_SW_W-1:0]     w_sum;
    logic [PERIOD_W-1:0]   w_period_swept;

`ifdef SFX_NOISE_EN
    logic                  r_noise_sel;
    logic [c_LFSR_W-1:0]   r_lfsr;
    logic [c_LFSR_W-1:0]   w_lfsr_next;

    // Next LFSR value: shift left, feedback XOR of the tap bits into the LSB
    always_comb begin
        w_lfsr_next = {r_lfsr[c_LFSR_W-2:0], ^(r_lfsr & c_LFSR_TAPS)};
    end
`endif

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Per-tick decodes; a coincident trigger swallows the tick
    always_comb begin
        w_play_tick  = (r_state == PLAY) && w_tick && !trigger;
        w_phase_wrap = ({1'b0, r_phase} + (PERIOD_W+1)'(1)) >= {1'b0, r_period};
        w_env_step   = (r_env_cnt == (r_env_len - 8'd1));
        w_last_step  = w_env_step && (r_volume == BIT_WIDTH'(1));
    end

    // Saturating period sweep clamped to [1, 2^PERIOD_W-1]
    always_comb begin
        w_per_ext  = c_SW_W'(r_period);
        w_step_ext = c_SW_W'(r_sweep_step);
        w_sum      = w_per_ext + w_step_ext;
        if (r_sweep_up) begin
            w_period_swept = (w_sum > c_SW_W'(c_PER_MAX)) ? c_PER_MAX : w_sum[PERIOD_W-1:0];
        end else begin
            w_period_swept = (w_per_ext > w_step_ext) ? PERIOD_W'(w_per_ext - w_step_ext)
                                                      : PERIOD_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: trigger always (re)enters PLAY, final decay step ends it
    always_comb begin
        w_state_next = r_state;
        if (trigger) begin
            w_state_next = PLAY;
        end else if (w_play_tick && w_last_step) begin
            w_state_next = IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == PLAY);
    end

    // Voice datapath: trigger load, per-tick phase/envelope/sweep, sample register.
    // The sample captured on a tick reflects the square/volume in force during
    // the interval that tick closes; the edge that ends the effect emits 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_volume       <= '0;
            r_period       <= PERIOD_W'(1);
            r_phase        <= '0;
            r_env_cnt      <= '0;
            r_env_len      <= 8'd1;
            r_sweep_step   <= '0;
            r_sweep_up     <= 1'b0;
            r_square       <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
`ifdef SFX_NOISE_EN
            r_noise_sel    <= 1'b0;
            r_lfsr         <= c_LFSR_SEED;
`endif
        end else if (trigger) begin
            r_volume       <= c_VOL_MAX;
            r_period       <= (start_period == '0) ? PERIOD_W'(1) : start_period;
            r_phase        <= '0;
            r_env_cnt      <= '0;
            r_env_len      <= (env_len == 8'd0) ? 8'd1 : env_len;
            r_sweep_step   <= sweep_step;
            r_sweep_up     <= sweep_up;
            r_square       <= 1'b1;
            r_sample_valid <= 1'b0;
`ifdef SFX_NOISE_EN
            r_noise_sel    <= noise_sel;
            r_lfsr         <= c_LFSR_SEED;
`endif
        end else begin
            r_sample_valid <= w_tick;
            if (w_play_tick) begin
                r_sample <= (w_last_step || !r_square) ? '0 : {1'b0, r_volume};

                if (w_phase_wrap) begin
                    r_phase <= '0;
`ifdef SFX_NOISE_EN
                    if (r_noise_sel) begin
                        r_lfsr   <= w_lfsr_next;
                        r_square <= w_lfsr_next[0];
                    end else begin
                        r_square <= ~r_square;
                    end
`else
                    r_square <= ~r_square;
`endif
                end else begin
                    r_phase <= r_phase + PERIOD_W'(1);
                end

                if (w_env_step) begin
                    r_env_cnt <= '0;
                    r_volume  <= r_volume - BIT_WIDTH'(1);
                    r_period  <= w_period_swept;
                end else begin
                    r_env_cnt <= r_env_cnt + 8'd1;
                end
            end else if (w_tick) begin
                r_sample <= '0;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;

endmodule
`default_nettype wire
